md_unit: RTL
============

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port A, input, 32 bits: operand 1 (rs value).
REQ-004 SHALL have port B, input, 32 bits: operand 2 (rt value).
REQ-005 SHALL have port op, input, 4 bits, with this encoding:
- 0 none; 1 mult; 2 multu; 3 div; 4 divu
- 5 mthi; 6 mtlo; 7 mfhi; 8 mflo; 9-15 none
REQ-006 SHALL have port start, input, 1 bit: qualifies op codes 1-6 for acceptance this cycle.
REQ-007 SHALL have port res, output, 32 bits: read data for mfhi/mflo.
REQ-008 SHALL have port busy, output, 1 bit: a multiply/divide is in progress.
REQ-009 SHALL have port hi, output, 32 bits: current HI register.
REQ-010 SHALL have port lo, output, 32 bits: current LO register.

Function
REQ-011 SHALL hold state: HI, LO, a 4-bit countdown, pending-HI/pending-LO registers and a pending-valid flag; FSM states IDLE and RUN.
REQ-012 SHALL accept a command only when start=1 in IDLE; start=1 in RUN SHALL be ignored, and the pipeline is expected to stall on busy.
REQ-013 SHALL, on an accepted mult/multu at edge T0, compute the 64-bit product of A and B (signed/unsigned respectively), latch it as pending {HI,LO}, load the countdown with 5 and enter RUN.
REQ-014 SHALL, on an accepted div/divu at edge T0, latch pending LO=quotient and HI=remainder, load the countdown with 10 and enter RUN.
REQ-015 SHALL, for signed division, truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-016 SHALL give 0x80000000 / 0xFFFFFFFF (signed) the result LO=0x80000000, HI=0.
REQ-017 SHALL, on divide by zero (B=0), still run 10 busy cycles but clear pending-valid, leaving HI/LO unchanged at completion.
REQ-018 SHALL drive busy=1 exactly while in RUN:
- mult/multu: for the 5 cycles after T0
- div/divu: for the 10 cycles after T0
REQ-019 SHALL decrement the countdown once per cycle in RUN.
REQ-020 SHALL, at the edge where the countdown equals 1, write pending to HI/LO (if pending-valid), clear the countdown and return to IDLE; busy SHALL fall in the same cycle HI/LO change.
REQ-021 SHALL, on accepted mthi (mtlo), write A into HI (LO) at that edge with no busy cycles; the other register is untouched.
REQ-022 SHALL drive res combinationally: op=7 gives HI, op=8 gives LO, any other op gives 0. It is independent of start and busy, and reads the committed HI/LO, never pending.
REQ-023 SHALL treat op codes 0 and 7-15 with start=1 as no-ops with no state change.
REQ-024 SHALL ensure hi/lo outputs never show pending values before commit.
REQ-025 SHALL use no combinational path from start or A/B to busy.
REQ-026 SHALL wrap all arithmetic modulo 2^32 per half; no overflow is flagged.

Reset
REQ-027 SHALL, while reset_n=0 (asynchronous, immediate), force:
- HI=0, LO=0, countdown=0, pending=0, pending-valid=0
- state IDLE, busy=0, hence res=0 for op 7/8
REQ-028 SHALL, on reset asserted mid-RUN, discard the in-flight result; HI/LO remain 0 after release.
REQ-029 SHALL accept a command in the first clock edge with reset_n=1.

Verification
REQ-030 SHALL cover: mult A=0xFFFFFFFF, B=2 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 SHALL cover: div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu A=7, B=2 -> LO=3, HI=1.
REQ-032 SHALL cover: mthi A=0x12345678, then mtlo A=0x9ABCDEF0 -> op=7 gives res=0x12345678, op=8 gives res=0x9ABCDEF0, busy never asserted.
REQ-033 SHALL cover: div with B=0 after mthi 0x55 -> busy 10 cycles; HI=0x55 and LO unchanged afterwards.
REQ-034 SHALL cover: start=1 op=5 during RUN of a mult -> ignored; HI equals the product high word at completion.
REQ-035 SHALL cover: reset_n pulsed low in busy cycle 3 of a div -> busy=0, HI=LO=0 immediately; no later commit.

Source files
------------

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit : multiply/divide unit with architectural HI/LO registers.
//
// Ports
//   clk     in   1  single clock, rising edge
//   reset_n in   1  asynchronous active-low reset
//   A       in  32  operand 1 (rs value)
//   B       in  32  operand 2 (rt value)
//   op      in   4  0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                   5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
//   start   in   1  qualifies op codes 1-6 for acceptance this cycle
//   res     out 32  mfhi/mflo read data (combinational)
//   busy    out  1  multiply/divide in progress
//   hi      out 32  committed HI register
//   lo      out 32  committed LO register
//
// The arithmetic result is computed in the accepting cycle and parked in
// pending registers.  A countdown then models the latency of a real
// iterative unit; only when it expires is the result copied into HI/LO.
// ---------------------------------------------------------------------------
module md_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  op,
  input  logic        start,
  output logic [31:0] res,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_valid;
  logic [3:0]  count;

  // ---------------------------------------------------------------------
  // Command decode.  Commands are only looked at in IDLE; anything that
  // arrives while RUN is dropped because the pipeline stalls on busy.
  // ---------------------------------------------------------------------
  logic accept;
  logic is_mul;
  logic is_div;
  logic do_mul;
  logic do_div;
  logic do_mthi;
  logic do_mtlo;
  logic commit;

  assign accept  = start && (state == IDLE);
  assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);
  assign do_mul  = accept && is_mul;
  assign do_div  = accept && is_div;
  assign do_mthi = accept && (op == OP_MTHI);
  assign do_mtlo = accept && (op == OP_MTLO);
  assign commit  = (state == RUN) && (count == 4'd1);

  // ---------------------------------------------------------------------
  // Multiplier.  The signed product is formed by sign-extending both
  // operands to 64 bits; the low 64 bits of that product are exactly the
  // two's-complement signed result.
  // ---------------------------------------------------------------------
  logic [63:0] a_sext;
  logic [63:0] b_sext;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] prod;

  assign a_sext = {{32{A[31]}}, A};
  assign b_sext = {{32{B[31]}}, B};
  assign prod_s = a_sext * b_sext;
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign prod   = (op == OP_MULT) ? prod_s : prod_u;

  // ---------------------------------------------------------------------
  // Divider.  Signed division goes through magnitudes so the quotient
  // truncates toward zero and the remainder follows the dividend's sign.
  // This also makes 0x80000000 / -1 fall out as 0x80000000 rem 0 with no
  // special case: the magnitude 0x80000000 is representable unsigned.
  // A zero divisor is replaced by 1 only to keep the arithmetic defined;
  // that result is never committed.
  // ---------------------------------------------------------------------
  logic        div_by_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_mag_safe;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_signed;
  logic [31:0] r_signed;
  logic [31:0] q_unsigned;
  logic [31:0] r_unsigned;
  logic [31:0] quot;
  logic [31:0] rem;

  assign div_by_zero = (B == 32'd0);
  assign a_mag       = A[31] ? (32'd0 - A) : A;
  assign b_mag       = B[31] ? (32'd0 - B) : B;
  assign b_mag_safe  = div_by_zero ? 32'd1 : b_mag;
  assign b_safe      = div_by_zero ? 32'd1 : B;

  assign q_mag       = a_mag / b_mag_safe;
  assign r_mag       = a_mag % b_mag_safe;
  assign q_signed    = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_signed    = A[31] ? (32'd0 - r_mag) : r_mag;

  assign q_unsigned  = A / b_safe;
  assign r_unsigned  = A % b_safe;

  assign quot = (op == OP_DIV) ? q_signed : q_unsigned;
  assign rem  = (op == OP_DIV) ? r_signed : r_unsigned;

  // ---------------------------------------------------------------------
  // FSM state register.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next-state logic: multiply/divide enter RUN, expiry of the
  // countdown returns to IDLE.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (do_mul || do_div) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (commit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM outputs.  busy depends on state only, so there is no path from
  // start/A/B to busy.
  // ---------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      RUN:     busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Countdown and pending result.  The pending registers are captured at
  // acceptance and stay hidden until the countdown expires.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= 4'd0;
      pend_hi    <= 32'd0;
      pend_lo    <= 32'd0;
      pend_valid <= 1'b0;
    end else if (do_mul) begin
      count      <= MULT_CYCLES;
      pend_hi    <= prod[63:32];
      pend_lo    <= prod[31:0];
      pend_valid <= 1'b1;
    end else if (do_div) begin
      count      <= DIV_CYCLES;
      pend_hi    <= rem;
      pend_lo    <= quot;
      pend_valid <= !div_by_zero;
    end else if (state == RUN) begin
      count <= count - 4'd1;
      if (commit) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Architectural HI/LO.  Written by mthi/mtlo at acceptance or by the
  // pending result on the commit edge; the two cannot coincide because
  // mthi/mtlo are only accepted in IDLE.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_reg <= 32'd0;
      lo_reg <= 32'd0;
    end else if (commit) begin
      if (pend_valid) begin
        hi_reg <= pend_hi;
        lo_reg <= pend_lo;
      end
    end else if (do_mthi) begin
      hi_reg <= A;
    end else if (do_mtlo) begin
      lo_reg <= A;
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

  // ---------------------------------------------------------------------
  // Read port: committed HI/LO only, regardless of start or busy.
  // ---------------------------------------------------------------------
  always_comb begin
    res = 32'd0;
    if (op == OP_MFHI) begin
      res = hi_reg;
    end else if (op == OP_MFLO) begin
      res = lo_reg;
    end
  end

endmodule
